// File: rtl/ula_seq.sv
// ============================================================================
// Module   : ula_seq
// Brief    : Multi-cycle ALU. Logic/arith ops finish in one cycle, shifts run
//            one bit per cycle, MUL is an LSB-first shift-add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [2:0] C_OP_ADD = 3'd0;
    localparam logic [2:0] C_OP_SUB = 3'd1;
    localparam logic [2:0] C_OP_AND = 3'd2;
    localparam logic [2:0] C_OP_OR  = 3'd3;
    localparam logic [2:0] C_OP_XOR = 3'd4;
    localparam logic [2:0] C_OP_SHL = 3'd5;
    localparam logic [2:0] C_OP_SHR = 3'd6;
    localparam logic [2:0] C_OP_MUL = 3'd7;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MUL = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               negative_q, negative_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SH_W-1:0]    w_shamt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_shift_out;
    logic               w_ld_en;
    logic [WIDTH-1:0]   w_ld_res;
    logic               w_ld_carry;
    logic               w_ld_ovf;

    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};
    assign w_shamt    = b[SH_W-1:0];
    // work_q doubles as the shifter operand and the (right-shifting) multiplier
    assign w_acc_next = acc_q + (work_q[0] ? mcand_q : '0);
    assign w_shift_next = (op_q == C_OP_SHL) ? (work_q << 1) : (work_q >> 1);
    assign w_shift_out  = (op_q == C_OP_SHL) ? work_q[WIDTH-1] : work_q[0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        w_ld_en    = 1'b0;
        w_ld_res   = '0;
        w_ld_carry = 1'b0;
        w_ld_ovf   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    case (op)
                        C_OP_ADD: begin
                            w_ld_en    = 1'b1;
                            w_ld_res   = w_sum[WIDTH-1:0];
                            w_ld_carry = w_sum[WIDTH];
                            w_ld_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        C_OP_SUB: begin
                            w_ld_en    = 1'b1;
                            w_ld_res   = w_diff[WIDTH-1:0];
                            w_ld_carry = w_diff[WIDTH];
                            w_ld_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        C_OP_AND: begin
                            w_ld_en  = 1'b1;
                            w_ld_res = a & b;
                        end
                        C_OP_OR: begin
                            w_ld_en  = 1'b1;
                            w_ld_res = a | b;
                        end
                        C_OP_XOR: begin
                            w_ld_en  = 1'b1;
                            w_ld_res = a ^ b;
                        end
                        C_OP_SHL, C_OP_SHR: begin
                            if (w_shamt == '0) begin
                                w_ld_en  = 1'b1;
                                w_ld_res = a;
                            end else begin
                                state_d = S_EXEC;
                                cnt_d   = {1'b0, w_shamt};
                                work_d  = a;
                            end
                        end
                        default: begin
                            state_d = S_EXEC;
                            cnt_d   = C_CNT_MUL;
                            work_d  = b;
                            mcand_d = {{WIDTH{1'b0}}, a};
                            acc_d   = '0;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - C_CNT_ONE;
                if (op_q == C_OP_MUL) begin
                    acc_d      = w_acc_next;
                    mcand_d    = mcand_q << 1;
                    work_d     = work_q >> 1;
                    w_ld_res   = w_acc_next[WIDTH-1:0];
                    w_ld_carry = |w_acc_next[2*WIDTH-1:WIDTH];
                end else begin
                    work_d     = w_shift_next;
                    w_ld_res   = w_shift_next;
                    w_ld_carry = w_shift_out;
                end
                if (cnt_q == C_CNT_ONE) begin
                    state_d = S_IDLE;
                    w_ld_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        result_d   = w_ld_en ? w_ld_res          : result_q;
        zero_d     = w_ld_en ? (w_ld_res == '0)  : zero_q;
        carry_d    = w_ld_en ? w_ld_carry        : carry_q;
        negative_d = w_ld_en ? w_ld_res[WIDTH-1] : negative_q;
        overflow_d = w_ld_en ? w_ld_ovf          : overflow_q;
        done_d     = w_ld_en;
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == S_EXEC);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_seq.sv
// ============================================================================
// Module   : tb_ula_seq
// Brief    : Scoreboard bench for ula_seq at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_seq;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic        c = 1'b0;
    logic        rst, start, busy, done, zero, carry, negative, overflow;
    logic [2:0]  op;
    logic [7:0]  a, b, result;
    logic        w_start, w_busy, w_done, w_zero, w_carry, w_negative, w_overflow;
    logic [2:0]  w_op;
    logic [15:0] w_a, w_b, w_result;

    typedef struct {
        logic [15:0] res;
        logic        z, cy, n, v;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;

    always #5 c = ~c;

    ula_seq #(.WIDTH(8)) dut (
        .c(c), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .carry(carry), .negative(negative), .overflow(overflow)
    );

    ula_seq #(.WIDTH(16)) dut16 (
        .c(c), .rst(rst), .start(w_start), .op(w_op), .a(w_a), .b(w_b),
        .busy(w_busy), .done(w_done), .result(w_result), .zero(w_zero),
        .carry(w_carry), .negative(w_negative), .overflow(w_overflow)
    );

    // Reference model in wide integer arithmetic
    function automatic exp_t model(int w, logic [2:0] o, logic [15:0] x, logic [15:0] y);
        exp_t   e;
        longint mask, ux, uy, sx, sy, r, sr, sh;
        mask = (longint'(1) << w) - 1;
        ux = longint'(x) & mask;
        uy = longint'(y) & mask;
        sx = (ux > (mask >> 1)) ? ux - (mask + 1) : ux;
        sy = (uy > (mask >> 1)) ? uy - (mask + 1) : uy;
        sh = uy % w;
        r = 0; sr = 0; e.cy = 1'b0; e.v = 1'b0; e.lat = 0;
        case (o)
            OP_ADD: begin
                r = ux + uy; e.cy = (r > mask); sr = sx + sy;
                e.v = (sr > (mask >> 1)) || (sr < -((mask >> 1) + 1));
            end
            OP_SUB: begin
                r = ux - uy; e.cy = (ux < uy); sr = sx - sy;
                e.v = (sr > (mask >> 1)) || (sr < -((mask >> 1) + 1));
            end
            OP_AND: r = ux & uy;
            OP_OR:  r = ux | uy;
            OP_XOR: r = ux ^ uy;
            OP_SHL: begin
                r = ux << sh; e.lat = int'(sh);
                e.cy = (sh != 0) ? (((ux >> (w - sh)) & 1) == 1) : 1'b0;
            end
            OP_SHR: begin
                r = ux >> sh; e.lat = int'(sh);
                e.cy = (sh != 0) ? (((ux >> (sh - 1)) & 1) == 1) : 1'b0;
            end
            default: begin
                r = ux * uy; e.cy = (r > mask); e.lat = w;
            end
        endcase
        r = r & mask;
        e.res = r[15:0];
        e.z   = (r == 0);
        e.n   = (((r >> (w - 1)) & 1) == 1);
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the acceptance edge with inputs scrambled
    task automatic drive_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(8, o, {8'h00, x}, {8'h00, y}));
        @(posedge c); #1;
        start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n >= 0) begin
            @(posedge c); #1;
            n++;
            if (n > 60) n = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; w_start = 1'b0;
        op = '0; a = '0; b = '0; w_op = '0; w_a = '0; w_b = '0;
        @(posedge c); #1;
        checks++;
        if ({busy, done, result, zero, carry, negative, overflow} !== {2'b00, 8'h00, 4'b1000}) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b res=%h zcnv=%b%b%b%b", busy, done, result, zero, carry, negative, overflow);
        end
        checks++;
        if ({w_busy, w_done, w_result, w_zero, w_carry, w_negative, w_overflow} !== {2'b00, 16'h0000, 4'b1000}) begin
            errors++;
            $display("FAIL reset16: got busy=%b done=%b res=%h", w_busy, w_done, w_result);
        end
        @(posedge c); #1;
        rst = 1'b0;
    endtask

    task automatic test_arith_logic();
        logic [2:0] t_op [7] = '{OP_ADD, OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB};
        logic [7:0] t_a  [7] = '{8'h04, 8'h01, 8'h7F, 8'hF0, 8'hF0, 8'hFF, 8'h80};
        logic [7:0] t_b  [7] = '{8'h01, 8'h02, 8'h01, 8'h3C, 8'h0F, 8'hFF, 8'h01};
        exp_t e;
        int   n;
        for (int i = 0; i < 7; i++) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            wait_done(n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) begin
                errors++; $display("FAIL alu%0d latency: got %0d expected %0d", i, n, e.lat);
            end
            checks++;
            if ({busy, result, zero, carry, negative, overflow} !== {1'b0, e.res[7:0], e.z, e.cy, e.n, e.v}) begin
                errors++;
                $display("FAIL alu%0d op=%0d: got busy=%b res=%h zcnv=%b%b%b%b expected busy=0 res=%h zcnv=%b%b%b%b",
                         i, t_op[i], busy, result, zero, carry, negative, overflow, e.res[7:0], e.z, e.cy, e.n, e.v);
            end
            @(posedge c); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL alu%0d done_pulse: got done=%b expected 0", i, done);
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0] t_op [6] = '{OP_SHL, OP_SHR, OP_SHL, OP_SHR, OP_SHL, OP_SHR};
        logic [7:0] t_a  [6] = '{8'h81, 8'h81, 8'h81, 8'h80, 8'hFF, 8'hF0};
        logic [7:0] t_b  [6] = '{8'h03, 8'h01, 8'h00, 8'h07, 8'h07, 8'h0C};
        exp_t e;
        int   n;
        for (int i = 0; i < 6; i++) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (busy !== (sb[0].lat > 0)) begin
                errors++; $display("FAIL shift%0d busy: got %b expected %b", i, busy, sb[0].lat > 0);
            end
            wait_done(n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) begin
                errors++; $display("FAIL shift%0d latency: got %0d expected %0d", i, n, e.lat);
            end
            checks++;
            if ({busy, result, zero, carry, negative, overflow} !== {1'b0, e.res[7:0], e.z, e.cy, e.n, e.v}) begin
                errors++;
                $display("FAIL shift%0d: got busy=%b res=%h zcnv=%b%b%b%b expected busy=0 res=%h zcnv=%b%b%b%b",
                         i, busy, result, zero, carry, negative, overflow, e.res[7:0], e.z, e.cy, e.n, e.v);
            end
            @(posedge c); #1;
        end
    endtask

    task automatic test_mul();
        logic [7:0] t_a [5] = '{8'd13, 8'h10, 8'hFF, 8'h00, 8'h80};
        logic [7:0] t_b [5] = '{8'd11, 8'h10, 8'hFF, 8'h55, 8'h01};
        exp_t e;
        int   n;
        for (int i = 0; i < 5; i++) begin
            drive_op(OP_MUL, t_a[i], t_b[i]);
            wait_done(n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) begin
                errors++; $display("FAIL mul%0d latency: got %0d expected %0d", i, n, e.lat);
            end
            checks++;
            if ({busy, result, zero, carry, negative, overflow} !== {1'b0, e.res[7:0], e.z, e.cy, e.n, e.v}) begin
                errors++;
                $display("FAIL mul%0d: got busy=%b res=%h zcnv=%b%b%b%b expected busy=0 res=%h zcnv=%b%b%b%b",
                         i, busy, result, zero, carry, negative, overflow, e.res[7:0], e.z, e.cy, e.n, e.v);
            end
            @(posedge c); #1;
        end
    endtask

    task automatic test_busy_ignore();
        exp_t        e;
        int          dones = 0;
        int          done_edge = -1;
        logic [11:0] seen = '0;
        drive_op(OP_MUL, 8'd13, 8'd11);
        for (int i = 1; i <= 7; i++) begin
            start = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge c); #1;
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        for (int j = 8; j <= 12; j++) begin
            @(posedge c); #1;
            if (done === 1'b1) begin
                dones++;
                done_edge = j;
                seen = {result, zero, carry, negative, overflow};
            end
        end
        e = sb.pop_front();
        checks++;
        if (dones !== 1 || done_edge !== 8) begin
            errors++; $display("FAIL busy_ignore count: got %0d dones at edge %0d expected 1 at edge 8", dones, done_edge);
        end
        checks++;
        if (seen !== {e.res[7:0], e.z, e.cy, e.n, e.v}) begin
            errors++; $display("FAIL busy_ignore result: got %h expected %h", seen, {e.res[7:0], e.z, e.cy, e.n, e.v});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        start = 1'b1; op = OP_ADD; a = 8'h03; b = 8'h04;
        sb.push_back(model(8, OP_ADD, 16'h0003, 16'h0004));
        @(posedge c); #1;
        e = sb.pop_front();
        checks++;
        if ({done, result} !== {1'b1, e.res[7:0]}) begin
            errors++; $display("FAIL b2b_first: got done=%b res=%h expected done=1 res=%h", done, result, e.res[7:0]);
        end
        op = OP_SUB; a = 8'h09; b = 8'h02;
        sb.push_back(model(8, OP_SUB, 16'h0009, 16'h0002));
        @(posedge c); #1;
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({done, result} !== {1'b1, e.res[7:0]}) begin
            errors++; $display("FAIL b2b_second: got done=%b res=%h expected done=1 res=%h", done, result, e.res[7:0]);
        end
        @(posedge c); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got done=%b expected 0", done);
        end
        drive_op(OP_SHL, 8'h0F, 8'h02);
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || result !== e.res[7:0]) begin
            errors++; $display("FAIL b2b_shift: got lat=%0d res=%h expected lat=%0d res=%h", n, result, e.lat, e.res[7:0]);
        end
        start = 1'b1; op = OP_ADD; a = 8'h10; b = 8'h20;
        sb.push_back(model(8, OP_ADD, 16'h0010, 16'h0020));
        @(posedge c); #1;
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({done, busy, result} !== {2'b10, e.res[7:0]}) begin
            errors++; $display("FAIL b2b_after_shift: got done=%b busy=%b res=%h expected done=1 busy=0 res=%h", done, busy, result, e.res[7:0]);
        end
        @(posedge c); #1;
    endtask

    task automatic test_rst_abort();
        exp_t e;
        int   n;
        int   dones = 0;
        start = 1'b1; op = OP_MUL; a = 8'd13; b = 8'd11;
        @(posedge c); #1;
        start = 1'b0;
        repeat (3) @(posedge c);
        #1 rst = 1'b1;
        @(posedge c); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, result, zero, carry, negative, overflow} !== {2'b00, 8'h00, 4'b1000}) begin
            errors++; $display("FAIL rst_abort: got busy=%b done=%b res=%h zcnv=%b%b%b%b expected reset values", busy, done, result, zero, carry, negative, overflow);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge c); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL rst_abort_nodone: got %0d dones expected 0", dones);
        end
        drive_op(OP_ADD, 8'h22, 8'h11);
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || result !== e.res[7:0]) begin
            errors++; $display("FAIL rst_recover: got lat=%0d res=%h expected lat=%0d res=%h", n, result, e.lat, e.res[7:0]);
        end
        // reset and start on the same edge: request must be dropped
        rst = 1'b1; start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
        @(posedge c); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge c); #1;
        checks++;
        if ({done, result, zero} !== {1'b0, 8'h00, 1'b1}) begin
            errors++; $display("FAIL rst_start: got done=%b res=%h zero=%b expected done=0 res=00 zero=1", done, result, zero);
        end
    endtask

    task automatic test_wide();
        logic [2:0]  t_op [5] = '{OP_ADD, OP_MUL, OP_MUL, OP_SUB, OP_SHR};
        logic [15:0] t_a  [5] = '{16'hFFFF, 16'd300, 16'h0100, 16'h0000, 16'h8001};
        logic [15:0] t_b  [5] = '{16'h0001, 16'd200, 16'h0100, 16'h0001, 16'h000F};
        exp_t e;
        int   n;
        for (int i = 0; i < 5; i++) begin
            w_start = 1'b1; w_op = t_op[i]; w_a = t_a[i]; w_b = t_b[i];
            sb16.push_back(model(16, t_op[i], t_a[i], t_b[i]));
            @(posedge c); #1;
            w_start = 1'b0; w_a = 16'($urandom); w_b = 16'($urandom);
            n = 0;
            while (w_done !== 1'b1 && n >= 0) begin
                @(posedge c); #1;
                n++;
                if (n > 60) n = -1;
            end
            e = sb16.pop_front();
            checks++;
            if (n !== e.lat) begin
                errors++; $display("FAIL wide%0d latency: got %0d expected %0d", i, n, e.lat);
            end
            checks++;
            if ({w_result, w_zero, w_carry, w_negative, w_overflow} !== {e.res, e.z, e.cy, e.n, e.v}) begin
                errors++;
                $display("FAIL wide%0d: got res=%h zcnv=%b%b%b%b expected res=%h zcnv=%b%b%b%b",
                         i, w_result, w_zero, w_carry, w_negative, w_overflow, e.res, e.z, e.cy, e.n, e.v);
            end
            @(posedge c); #1;
        end
    endtask

    initial begin
        test_reset();
        test_arith_logic();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_back_to_back();
        test_rst_abort();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
